// File: rtl/ex_mem_pipe_pkg.sv
// Shared types and constants for the EX->MEM pipeline register.
package ex_mem_pipe_pkg;

  localparam int EM_DATA_W = 32;
  localparam int EM_ADDR_W = 10;
  localparam int EM_RAW    = 5;
  localparam int EM_OP_W   = 4;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [EM_OP_W-1:0] ALUOP_NOP = 4'h0;
  localparam logic [EM_OP_W-1:0] ALUOP_LW  = 4'h1;
  localparam logic [EM_OP_W-1:0] ALUOP_SW  = 4'h2;

  typedef struct packed {
    logic [EM_RAW-1:0]    wd;
    logic                 wreg;
    logic [EM_DATA_W-1:0] wdata;
    logic                 of;
    logic                 zf;
    logic [EM_OP_W-1:0]   aluop;
    logic [EM_ADDR_W-1:0] mem_addr;
    logic [EM_DATA_W-1:0] reg2;
  } ex_mem_bundle_t;

endpackage

// File: rtl/ex_mem_pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer; in_ready comes straight from a flop.
module pipe_skid_buf
  import ex_mem_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic         acc, pop;

  assign in_ready  = !skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;
  assign acc       = in_valid & !skid_v_q;
  assign pop       = main_v_q & out_ready;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      // Payload is left in place; only the valid bits are killed.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (pop) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end
    end else if (acc) begin
      if (!main_v_q || pop) begin
        main_d   = in_data;
        main_v_d = 1'b1;
      end else begin
        skid_d   = in_data;
        skid_v_d = 1'b1;
      end
    end else if (pop) begin
      main_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register: skid-buffered bundle, gated write enable and ID bypass tap.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RAW    = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [RAW-1:0]    ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_of,
  input  logic              ex_zf,
  input  logic [OP_W-1:0]   ex_aluop,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_reg2,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [RAW-1:0]    mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_of,
  output logic              mem_zf,
  output logic [OP_W-1:0]   mem_aluop,
  output logic [ADDR_W-1:0] mem_mem_addr,
  output logic [DATA_W-1:0] mem_reg2,
  output logic              fwd_wen,
  output logic [RAW-1:0]    fwd_wd,
  output logic [DATA_W-1:0] fwd_wdata
);

  // Same layout as ex_mem_bundle_t, sized from this instance's parameters.
  typedef struct packed {
    logic [RAW-1:0]    wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              of;
    logic              zf;
    logic [OP_W-1:0]   aluop;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] reg2;
  } bundle_t;

  bundle_t in_b, head;

  assign in_b = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, of: ex_of, zf: ex_zf,
                  aluop: ex_aluop, mem_addr: ex_mem_addr, reg2: ex_reg2};

  pipe_skid_buf #(.W($bits(bundle_t))) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (ex_valid),
    .in_ready  (ex_ready),
    .in_data   (in_b),
    .out_valid (mem_valid),
    .out_ready (mem_ready),
    .out_data  (head)
  );

  assign mem_wd       = head.wd;
  assign mem_wreg     = mem_valid ? head.wreg : WriteDisable;
  assign mem_wdata    = head.wdata;
  assign mem_of       = head.of;
  assign mem_zf       = head.zf;
  assign mem_aluop    = head.aluop;
  assign mem_mem_addr = head.mem_addr;
  assign mem_reg2     = head.reg2;

  assign fwd_wen   = mem_valid & (head.wreg == WriteEnable);
  assign fwd_wd    = head.wd;
  assign fwd_wdata = head.wdata;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed scenarios plus random traffic against a queue model.
module tb_ex_mem_pipe;
  import ex_mem_pipe_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int RAW    = 5;
  localparam int OP_W   = 4;

  logic clk = 1'b0;
  logic rst, flush, ex_valid, mem_ready;
  ex_mem_bundle_t in_b;

  logic              ex_ready, mem_valid, mem_wreg, mem_of, mem_zf, fwd_wen;
  logic [RAW-1:0]    ex_wd, mem_wd, fwd_wd;
  logic              ex_wreg, ex_of, ex_zf;
  logic [DATA_W-1:0] ex_wdata, ex_reg2, mem_wdata, mem_reg2, fwd_wdata;
  logic [OP_W-1:0]   ex_aluop, mem_aluop;
  logic [ADDR_W-1:0] ex_mem_addr, mem_mem_addr;
  ex_mem_bundle_t    obs_b;

  int n_checks = 0;
  int n_pass   = 0;

  ex_mem_bundle_t q[$];

  always #5 clk = ~clk;

  assign ex_wd       = in_b.wd;
  assign ex_wreg     = in_b.wreg;
  assign ex_wdata    = in_b.wdata;
  assign ex_of       = in_b.of;
  assign ex_zf       = in_b.zf;
  assign ex_aluop    = in_b.aluop;
  assign ex_mem_addr = in_b.mem_addr;
  assign ex_reg2     = in_b.reg2;
  assign obs_b = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata, of: mem_of, zf: mem_zf,
                   aluop: mem_aluop, mem_addr: mem_mem_addr, reg2: mem_reg2};

  ex_mem_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAW(RAW), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_of(ex_of), .ex_zf(ex_zf),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_of(mem_of), .mem_zf(mem_zf), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .fwd_wen(fwd_wen), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata)
  );

  // Reference: a two-deep FIFO; space is judged on the occupancy at the start of the cycle.
  task automatic model_edge();
    bit room, have;
    room = (q.size() < 2);
    have = (q.size() > 0);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (have && mem_ready) void'(q.pop_front());
      if (ex_valid && room) q.push_back(in_b);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ex_mem_bundle_t mk(int wd, bit wreg, logic [31:0] wdata);
    ex_mem_bundle_t b = '0;
    b.wd    = 5'(wd);
    b.wreg  = wreg;
    b.wdata = wdata;
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b1; mem_ready = 1'b0;
    in_b = mk(9, 1'b1, 32'hCAFE0001);
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid got %b want 0", mem_valid); else n_pass++;
    n_checks++; if (ex_ready !== 1'b1) $display("FAIL reset_ex_ready got %b want 1", ex_ready); else n_pass++;
    n_checks++; if (fwd_wen !== 1'b0) $display("FAIL reset_fwd_wen got %b want 0", fwd_wen); else n_pass++;
    n_checks++; if (obs_b !== '0) $display("FAIL reset_fields got %h want 0", obs_b); else n_pass++;
    n_checks++; if ({fwd_wd, fwd_wdata} !== '0) $display("FAIL reset_fwd got %h want 0", {fwd_wd, fwd_wdata}); else n_pass++;
    ex_valid = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    mem_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ex_valid = 1'b1;
      in_b = mk(i, 1'b1, 32'h100 + i);
      tick();
      n_checks++; if (mem_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", i, mem_valid); else n_pass++;
      n_checks++; if (obs_b !== mk(i, 1'b1, 32'h100 + i)) $display("FAIL stream_head[%0d] got %h want %h", i, obs_b, mk(i, 1'b1, 32'h100 + i)); else n_pass++;
      n_checks++; if (ex_ready !== 1'b1) $display("FAIL stream_ready[%0d] got %b want 1", i, ex_ready); else n_pass++;
    end
    ex_valid = 1'b0;
    tick();
    n_checks++; if (mem_valid !== 1'b0) $display("FAIL stream_drain got %b want 0", mem_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b0;
    ex_valid = 1'b1; in_b = mk(3, 1'b1, 32'hA);
    tick();
    in_b = mk(4, 1'b1, 32'hB);
    tick();
    in_b = mk(5, 1'b1, 32'hC);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (ex_ready !== 1'b0) $display("FAIL bp_ready_low[%0d] got %b want 0", k, ex_ready); else n_pass++;
      n_checks++; if (obs_b !== mk(3, 1'b1, 32'hA) || mem_valid !== 1'b1) $display("FAIL bp_head_A[%0d] got %h want %h", k, obs_b, mk(3, 1'b1, 32'hA)); else n_pass++;
      tick();
    end
    mem_ready = 1'b1;
    n_checks++; if (mem_wd !== 5'd3) $display("FAIL bp_out_A got %0d want 3", mem_wd); else n_pass++;
    tick();
    n_checks++; if (obs_b !== mk(4, 1'b1, 32'hB) || mem_valid !== 1'b1) $display("FAIL bp_out_B got %h want %h", obs_b, mk(4, 1'b1, 32'hB)); else n_pass++;
    n_checks++; if (ex_ready !== 1'b1) $display("FAIL bp_ready_back got %b want 1", ex_ready); else n_pass++;
    tick();
    ex_valid = 1'b0;
    n_checks++; if (obs_b !== mk(5, 1'b1, 32'hC) || mem_valid !== 1'b1) $display("FAIL bp_out_C got %h want %h", obs_b, mk(5, 1'b1, 32'hC)); else n_pass++;
    tick();
    n_checks++; if (mem_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", mem_valid); else n_pass++;
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    ex_valid = 1'b1; in_b = mk(10, 1'b1, 32'hA);
    tick();
    in_b = mk(11, 1'b1, 32'hB);
    tick();
    n_checks++; if (ex_ready !== 1'b0) $display("FAIL flush_pre_full got %b want 0", ex_ready); else n_pass++;
    flush = 1'b1; in_b = mk(12, 1'b1, 32'hC);
    tick();
    flush = 1'b0; ex_valid = 1'b0;
    n_checks++; if (mem_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", mem_valid); else n_pass++;
    n_checks++; if (fwd_wen !== 1'b0 || mem_wreg !== 1'b0) $display("FAIL flush_wen got %b/%b want 0/0", fwd_wen, mem_wreg); else n_pass++;
    n_checks++; if (ex_ready !== 1'b1) $display("FAIL flush_ready got %b want 1", ex_ready); else n_pass++;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (mem_valid !== 1'b0) $display("FAIL flush_no_C[%0d] got %b want 0", k, mem_valid); else n_pass++;
    end
  endtask

  task automatic test_forwarding();
    mem_ready = 1'b0;
    ex_valid = 1'b1; in_b = mk(7, 1'b1, 32'hDEADBEEF);
    tick();
    ex_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (fwd_wen !== 1'b1 || fwd_wd !== 5'd7 || fwd_wdata !== 32'hDEADBEEF)
        $display("FAIL fwd_stall[%0d] got %b/%0d/%h want 1/7/deadbeef", k, fwd_wen, fwd_wd, fwd_wdata);
      else n_pass++;
      tick();
    end
    mem_ready = 1'b1;
    tick();
    n_checks++; if (fwd_wen !== 1'b0 || mem_valid !== 1'b0) $display("FAIL fwd_after_pop got %b/%b want 0/0", fwd_wen, mem_valid); else n_pass++;
  endtask

  task automatic test_store_reset();
    ex_mem_bundle_t s = '0;
    s.wd = 5'd2; s.aluop = ALUOP_SW; s.mem_addr = 10'h3FF; s.reg2 = 32'h12345678;
    s.of = 1'b1; s.zf = 1'b1; s.wdata = 32'h0000_03FF;
    mem_ready = 1'b0;
    ex_valid = 1'b1; in_b = s;
    tick();
    ex_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_b !== s || mem_valid !== 1'b1) $display("FAIL store_fields[%0d] got %h want %h", k, obs_b, s); else n_pass++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs_b !== '0 || mem_valid !== 1'b0 || fwd_wen !== 1'b0 || {fwd_wd, fwd_wdata} !== '0)
      $display("FAIL stall_reset got %h/%b/%b want 0/0/0", obs_b, mem_valid, fwd_wen);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [127:0] r;
    for (int c = 0; c < 400; c++) begin
      ex_valid  = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      r = {$urandom, $urandom, $urandom, $urandom};
      in_b = r[$bits(ex_mem_bundle_t)-1:0];
      n_checks++; if (ex_ready !== (q.size() < 2)) $display("FAIL rnd_ready[%0d] got %b want %b", c, ex_ready, q.size() < 2); else n_pass++;
      n_checks++; if (mem_valid !== (q.size() > 0)) $display("FAIL rnd_valid[%0d] got %b want %b", c, mem_valid, q.size() > 0); else n_pass++;
      if (q.size() > 0) begin
        n_checks++; if (obs_b !== q[0]) $display("FAIL rnd_head[%0d] got %h want %h", c, obs_b, q[0]); else n_pass++;
        n_checks++;
        if (fwd_wen !== q[0].wreg || fwd_wd !== q[0].wd || fwd_wdata !== q[0].wdata)
          $display("FAIL rnd_fwd[%0d] got %b/%h/%h want %b/%h/%h", c, fwd_wen, fwd_wd, fwd_wdata, q[0].wreg, q[0].wd, q[0].wdata);
        else n_pass++;
      end else begin
        n_checks++; if (fwd_wen !== 1'b0 || mem_wreg !== 1'b0) $display("FAIL rnd_idle_wen[%0d] got %b/%b want 0/0", c, fwd_wen, mem_wreg); else n_pass++;
      end
      tick();
    end
    flush = 1'b0; ex_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0; in_b = '0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_forwarding();
    test_store_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
Name:
ex_mem_pipe

Overview:
- Parametrised EX→MEM pipeline register with a valid/ready handshake and a one-entry skid buffer.
- Carries the writeback fields (dest reg, write enable, data), ALU flags (OF, ZF) and memory-access fields (aluop, address, store data).
- Lets MEM stall for multi-cycle memory without a combinational ready path back into EX.
- Supports a synchronous flush and drives a forwarding tap for the ID-stage bypass network.

Parameters:
- DATA_W, 32, width of wdata and store data (reg2).
- ADDR_W, 10, width of the memory address.
- RAW, 5, register-file address width.
- OP_W, 4, width of the aluop field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  kills all held entries; drops any input offered this cycle.
- ex_valid  in  1  EX presents a valid bundle.
- ex_ready  out  1  block can accept; registered.
- ex_wd  in  RAW  destination register.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  DATA_W  writeback value.
- ex_of, ex_zf  in  1 each  overflow and zero flags.
- ex_aluop  in  OP_W  load/store selector.
- ex_mem_addr  in  ADDR_W  memory address.
- ex_reg2  in  DATA_W  store data.
- mem_valid  out  1  head entry valid.
- mem_ready  in  1  MEM consumes the head this cycle.
- mem_wd, mem_wreg, mem_wdata, mem_of, mem_zf, mem_aluop, mem_mem_addr, mem_reg2  out  head-entry fields, same widths as the inputs.
- fwd_wen  out  1  head is valid and writes a register: mem_valid & head.wreg.
- fwd_wd  out  RAW  equals mem_wd.
- fwd_wdata  out  DATA_W  equals mem_wdata.

Behaviour:
- Storage is two bundle registers: main (the head, drives the mem_* outputs) and skid. Each has its own valid bit.
- mem_valid = main_v.
- ex_ready = !skid_v, taken directly from the flop. There is no path from mem_ready to ex_ready.
- Handshakes:
  - acc = ex_valid & ex_ready.
  - pop = main_v & mem_ready.
- Priority order: rst, then flush, then normal update.
- rst:
  - main_v = 0, skid_v = 0.
  - All payload fields zero, so mem_wreg = 0 and aluop = 0.
  - ex_ready = 1 from the first cycle after reset.
- flush:
  - main_v and skid_v are cleared next cycle; acc is ignored that cycle.
  - Payload registers hold their values.
  - mem_wreg output is gated with main_v, so a flushed entry never requests a write.
- Normal update, per cycle:
  - skid_v = 1 and pop: skid moves into main, skid_v goes to 0. ex_ready was 0, so no acc is possible.
  - skid_v = 0, acc, and (!main_v or pop): input loads main.
  - skid_v = 0, acc, main_v and !pop: input loads skid, skid_v goes to 1. ex_ready drops the next cycle.
  - pop with no refill: main_v goes to 0.
  - Otherwise everything holds.
- Latency and throughput:
  - A bundle accepted in cycle N is visible on mem_* in cycle N+1.
  - One bundle per cycle when mem_ready stays high.
- Ordering: FIFO. Skid always drains before any new input reaches main.
- Outputs are stable while mem_valid & !mem_ready; MEM may sample them on any cycle.
- mem_ready is ignored while main_v = 0.
- Fields are copied unchanged; there is no width conversion.

Decomposition:
- Shared package holds:
  - the ex_mem_bundle_t struct (wd, wreg, wdata, of, zf, aluop, mem_addr, reg2), built from the parameters;
  - RstEnable, WriteEnable, WriteDisable;
  - the load/store aluop constants.
- Natural sub-module: pipe_skid_buf. It is a generic two-entry valid/ready skid buffer on a packed vector with a flush input.
- ex_mem_pipe instantiates pipe_skid_buf with the packed bundle and adds the wreg gating and the forwarding tap.

Test Plan:
- Reset: assert rst for 2 cycles with ex_valid = 1 → mem_valid = 0, all mem_* = 0, fwd_wen = 0, ex_ready = 1 on the first cycle after release.
- Streaming: mem_ready = 1, present wd = 1..8 with wdata = 0x100+i on back-to-back cycles → each appears exactly one cycle later, in order, with no bubbles, and ex_ready stays 1.
- Backpressure:
  - mem_ready = 0, push A (wd = 3) then B (wd = 4) → head = A, ex_ready = 0 after B; C is held off with no loss.
  - Raise mem_ready → outputs A, B, C in consecutive cycles.
- Flush with full skid: main = A, skid = B, flush = 1 with ex_valid = 1 carrying C → next cycle mem_valid = 0, fwd_wen = 0, ex_ready = 1; C is never output.
- Forwarding: head with wreg = 1, wd = 7, wdata = 0xDEADBEEF, held under mem_ready = 0 → fwd_wen = 1, fwd_wd = 7, fwd_wdata = 0xDEADBEEF every stalled cycle. After the pop with no refill, fwd_wen = 0.
- Store path plus mid-stall reset: aluop = store, mem_addr = 0x3FF, reg2 = 0x12345678, with of = 1, zf = 1 → all fields exact at the output. Assert rst while stalled → all outputs zero the next cycle.
